// File: rtl/rambam_inverter_pkg.sv
// Shared types and constants for the RAMBAM GF(2^8) inverter.
// The optional LFSR randomness source is selected by RAMBAM_INV_LFSR_EN.
package rambam_inverter_pkg;

    localparam int D_DEFAULT = 4;
    localparam int MAX_D     = 8;
    localparam int MAX_W     = 8 + MAX_D;
    localparam int BEXT_W    = MAX_D * MAX_W;
    localparam int INV_STEPS = 11;
    localparam int STEP_W    = 4;

    // AES field polynomial x^8 + x^4 + x^3 + x + 1
    localparam logic [8:0] P_AES = 9'h11B;

    localparam logic [31:0] LFSR_SEED = 32'hACE1_2468;
    // Right-shifting Galois taps for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DONE
    } inv_state_t;

    typedef enum logic [1:0] {
        OPA_X,
        OPA_X2,
        OPA_ACC
    } opa_sel_t;

    typedef enum logic [2:0] {
        OPB_X,
        OPB_X2,
        OPB_X3,
        OPB_X12,
        OPB_ACC
    } opb_sel_t;

    typedef enum logic [1:0] {
        DST_X2,
        DST_X3_ACC,
        DST_ACC,
        DST_ACC_X12
    } dst_sel_t;

    // Row i of the encoder matrix is x^i * P(x): adding any XOR of rows
    // moves a codeword within its residue class mod P. Rows use MAX_W stride.
    function automatic logic [BEXT_W-1:0] gen_b_ext(input int dd);
        logic [BEXT_W-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_D; i++) begin
            if (i < dd) begin
                m[i*MAX_W +: MAX_W] = {7'b0, P_AES} << i;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/rambam_clm_mul.sv
// Combinational RAMBAM multiplier: carry-less product of two (8+d)-bit
// codewords reduced mod P(x)*x^d, then re-randomised by adding r*P(x)
// through the encoder matrix B_ext. Independent of RAMBAM_INV_LFSR_EN.
module rambam_clm_mul
    import rambam_inverter_pkg::*;
#(
    parameter int                d     = D_DEFAULT,
    parameter logic [BEXT_W-1:0] B_ext = gen_b_ext(d)
) (
    input  logic [8+d-1:0] a_i,
    input  logic [8+d-1:0] b_i,
    input  logic [d-1:0]   r_i,
    output logic [8+d-1:0] p_o
);

    localparam int W  = 8 + d;
    localparam int PW = 2 * W - 1;
    localparam logic [PW-1:0] QEXT = {{(W-2){1'b0}}, P_AES, {d{1'b0}}};

    logic [PW-1:0] prod;

    // Multiply, reduce from the top bit down, then add the random mask.
    always_comb begin
        prod = '0;
        for (int i = 0; i < W; i++) begin
            if (b_i[i]) begin
                prod = prod ^ ({{(W-1){1'b0}}, a_i} << i);
            end
        end
        for (int i = PW - 1; i >= W; i--) begin
            if (prod[i]) begin
                prod = prod ^ (QEXT << (i - W));
            end
        end
        p_o = prod[W-1:0];
        for (int j = 0; j < d; j++) begin
            if (r_i[j]) begin
                p_o = p_o ^ B_ext[j*MAX_W +: W];
            end
        end
    end

endmodule

// File: rtl/rambam_inv_lfsr.sv
// 32-bit Galois LFSR supplying multiplier randomness. Only built when
// RAMBAM_INV_LFSR_EN is defined; the default build contains no LFSR.
`ifdef RAMBAM_INV_LFSR_EN
module rambam_inv_lfsr
    import rambam_inverter_pkg::*;
#(
    parameter int d = D_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         adv_i,
    input  logic         seed_en_i,
    input  logic [d-1:0] seed_i,
    output logic [d-1:0] r_o
);

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;

    // Reseed on input handshake, otherwise step once per compute cycle.
    always_comb begin
        lfsr_d = lfsr_q;
        if (seed_en_i) begin
            lfsr_d[d-1:0] = lfsr_q[d-1:0] ^ seed_i;
        end else if (adv_i) begin
            lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
        end
    end

    // LFSR state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign r_o = lfsr_q[d-1:0];

endmodule
`endif

// File: rtl/rambam_inverter.sv
// Sequential RAMBAM GF(2^8) inverter: x^254 via an 11-step
// square-and-multiply chain on one shared multiplier.
// RAMBAM_INV_LFSR_EN: draw multiplier randomness from an internal LFSR
// (reseeded from rand_in at each input handshake) instead of rand_in.
//
// state   | meaning
// IDLE    | waiting for an input, in_ready high
// COMPUTE | one chain step per cycle, step counter 0..10
// DONE    | result held on out_data until out_ready
module rambam_inverter
    import rambam_inverter_pkg::*;
#(
    parameter int                d     = D_DEFAULT,
    parameter logic [BEXT_W-1:0] B_ext = gen_b_ext(d)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [8+d-1:0] in_data,
    input  logic [d-1:0]   rand_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [8+d-1:0] out_data
);

    localparam int W = 8 + d;

    inv_state_t        state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [W-1:0]      x_q, x_d;
    logic [W-1:0]      x2_q, x2_d;
    logic [W-1:0]      x3_q, x3_d;
    logic [W-1:0]      x12_q, x12_d;
    logic [W-1:0]      acc_q, acc_d;

    opa_sel_t          opa_sel;
    opb_sel_t          opb_sel;
    dst_sel_t          dst_sel;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic [d-1:0]      mul_r;
    logic [W-1:0]      mul_p;
    logic              last_step;

    assign last_step = (step_q == STEP_W'(INV_STEPS - 1));

    // Per-step operand and destination table; unlisted steps square acc.
    always_comb begin
        opa_sel = OPA_ACC;
        opb_sel = OPB_ACC;
        dst_sel = DST_ACC;
        case (step_q)
            4'd0: begin
                opa_sel = OPA_X;
                opb_sel = OPB_X;
                dst_sel = DST_X2;
            end
            4'd1: begin
                opa_sel = OPA_X2;
                opb_sel = OPB_X;
                dst_sel = DST_X3_ACC;
            end
            4'd3:    dst_sel = DST_ACC_X12;
            4'd4:    opb_sel = OPB_X3;
            4'd9:    opb_sel = OPB_X12;
            4'd10:   opb_sel = OPB_X2;
            default: ;
        endcase
    end

    // Operand multiplexers in front of the shared multiplier.
    always_comb begin
        case (opa_sel)
            OPA_X:   mul_a = x_q;
            OPA_X2:  mul_a = x2_q;
            default: mul_a = acc_q;
        endcase
        case (opb_sel)
            OPB_X:   mul_b = x_q;
            OPB_X2:  mul_b = x2_q;
            OPB_X3:  mul_b = x3_q;
            OPB_X12: mul_b = x12_q;
            default: mul_b = acc_q;
        endcase
    end

`ifdef RAMBAM_INV_LFSR_EN
    rambam_inv_lfsr #(
        .d(d)
    ) u_lfsr (
        .clk       (clk),
        .rst_n     (rst_n),
        .adv_i     (state_q == COMPUTE),
        .seed_en_i (in_valid && (state_q == IDLE)),
        .seed_i    (rand_in),
        .r_o       (mul_r)
    );
`else
    assign mul_r = rand_in;
`endif

    rambam_clm_mul #(
        .d     (d),
        .B_ext (B_ext)
    ) u_mul (
        .a_i (mul_a),
        .b_i (mul_b),
        .r_i (mul_r),
        .p_o (mul_p)
    );

    // Next-state, step sequencing and result write-back.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        x_d     = x_q;
        x2_d    = x2_q;
        x3_d    = x3_q;
        x12_d   = x12_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = in_data;
                    step_d  = '0;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                case (dst_sel)
                    DST_X2: x2_d = mul_p;
                    DST_X3_ACC: begin
                        x3_d  = mul_p;
                        acc_d = mul_p;
                    end
                    DST_ACC_X12: begin
                        x12_d = mul_p;
                        acc_d = mul_p;
                    end
                    default: acc_d = mul_p;
                endcase
                if (last_step) begin
                    state_d = DONE;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any computation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            x_q     <= '0;
            x2_q    <= '0;
            x3_q    <= '0;
            x12_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            x_q     <= x_d;
            x2_q    <= x2_d;
            x3_q    <= x3_d;
            x12_q   <= x12_d;
            acc_q   <= acc_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = acc_q;

endmodule

// File: tb/tb_rambam_inverter.sv
// Bench for rambam_inverter; also covers the RAMBAM_INV_LFSR_EN build.
module tb_rambam_inverter;

    localparam int D = 4;
    localparam int W = 8 + D;
    localparam logic [31:0] SEED = 32'hACE1_2468;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [D-1:0] rand_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    int n_checks = 0;
    int n_err    = 0;
    bit rnd_mode = 0;

    rambam_inverter #(.d(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rand_in   (rand_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gf_mul8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] aes_inv(input logic [7:0] a);
        if (a == 8'h00) return 8'h00;
        for (int b = 1; b < 256; b++) begin
            if (gf_mul8(a, 8'(b)) == 8'h01) return 8'(b);
        end
        return 8'h00;
    endfunction

    // Residue of the codeword polynomial mod the AES polynomial.
    function automatic logic [7:0] decode(input logic [W-1:0] c);
        logic [31:0] v;
        v = 32'(c);
        for (int i = 31; i >= 8; i--) begin
            if (v[i]) v = v ^ (32'h11B << (i - 8));
        end
        return v[7:0];
    endfunction

    // Plain value plus an optional random multiple of P.
    function automatic logic [W-1:0] encode(input logic [7:0] a, input bit rnd);
        logic [31:0] v;
        logic [31:0] m;
        v = {24'h0, a};
        m = rnd ? $urandom_range((1 << D) - 1, 0) : 32'h0;
        for (int i = 0; i < D; i++) begin
            if (m[i]) v = v ^ (32'h11B << i);
        end
        return v[W-1:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_mode) rand_in = D'($urandom);
    endtask

    task automatic xfer(input logic [7:0] a, input bit rand_enc, input bit chk_lat, input string tag);
        int cyc;
        in_valid = 1'b1;
        in_data  = encode(a, rand_enc);
        cyc = 0;
        while (!in_ready && cyc < 40) begin
            tick();
            cyc++;
        end
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_data  = W'($urandom);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        if (chk_lat) check({tag, "_latency"}, 32'(cyc), 32'd11);
        check({tag, "_result"}, 32'(decode(out_data)), 32'(aes_inv(a)));
        if (out_ready) begin
            tick();
            check({tag, "_release"}, {30'b0, out_valid, in_ready}, 32'b01);
        end
    endtask

    initial begin
        logic [W-1:0] held;
        logic [D-1:0] first_r;
        int           cyc;
        int           changes;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        rand_in   = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);

`ifdef RAMBAM_INV_LFSR_EN
        // First r after reset with rand_in=0 is the seed's low bits.
        in_valid = 1'b1;
        in_data  = encode(8'h53, 1'b0);
        tick();
        in_valid = 1'b0;
        check("lfsr_first_r", 32'(dut.mul_r), 32'(SEED[D-1:0]));
        first_r = dut.mul_r;
        changes = 0;
        cyc     = 0;
        while (!out_valid && cyc < 40) begin
            tick();
            cyc++;
            if (!out_valid && dut.mul_r != first_r) changes++;
        end
        check("lfsr_r_changes", 32'(changes != 0), 32'd1);
        check("lfsr_result", 32'(decode(out_data)), 32'hCA);
        tick();
`endif

        // Directed: 0x53 with zero randomness and exact latency.
        xfer(8'h53, 1'b0, 1'b1, "x53");

        // Small set under several random streams.
        rnd_mode = 1;
        for (int rep = 0; rep < 3; rep++) begin
            xfer(8'h01, 1'b0, 1'b1, "x01");
            xfer(8'h02, 1'b0, 1'b0, "x02");
            xfer(8'h00, 1'b0, 1'b0, "x00");
        end

        // Backpressure with in_valid pulsed during COMPUTE and DONE.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = encode(8'h02, 1'b1);
        tick();
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            check("bp_busy_ready", 32'(in_ready), 32'd0);
            in_data = W'($urandom);
            tick();
            cyc++;
        end
        check("bp_latency", 32'(cyc), 32'd11);
        held = out_data;
        for (int k = 0; k < 5; k++) begin
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_ready", 32'(in_ready), 32'd0);
            check("bp_hold_data", 32'(out_data), 32'(held));
            in_data = W'($urandom);
            tick();
        end
        check("bp_result", 32'(decode(held)), 32'h8D);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_handshake", {30'b0, out_valid, in_ready}, 32'b01);
        tick();
        check("bp_no_extra", {30'b0, out_valid, in_ready}, 32'b01);

        // Asynchronous reset during step 6.
        in_valid = 1'b1;
        in_data  = encode(8'h53, 1'b1);
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_data", 32'(out_data), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        xfer(8'h53, 1'b0, 1'b1, "after_rst");

        // Exhaustive sweep with random encodings and randomness.
        for (int a = 0; a < 256; a++) begin
            xfer(8'(a), 1'b1, 1'b0, "sweep");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/rambam_inverter.md
Name: rambam_inverter

Overview:
- Sequential GF(2^8) inverter over the redundant RAMBAM representation (8+d bits per element).
- Computes x^254 with an 11-step square-and-multiply chain. All steps reuse one instance of the existing combinational CLM multiplier.
- Sits upstream of the S-box affine stage and is the sole driver of the multiplier.
- Supplies fresh randomness r to the multiplier on every step.

Parameters:
- d, default `d: redundancy width; element width is 8+d.
- B_ext, default `B_ext: systematic-encoder matrix, passed unchanged to the multiplier.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept an input.
- in_data  input  8+d  element x to invert.
- rand_in  input  d  fresh randomness, sampled every COMPUTE cycle.
- out_valid  output  1  out_data holds x^254.
- out_ready  input  1  downstream accepts the result.
- out_data  output  8+d  result x^254 in redundant form.

Behaviour:
- Reset (asynchronous, any state, including mid-computation): state=IDLE, in_ready=1, out_valid=0, out_data=0. Registers x, x2, x3, x12, acc and step counter all cleared. A computation in progress is abandoned.
- States: IDLE -> COMPUTE -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch x=in_data, step=0, go to COMPUTE.
- COMPUTE:
  - in_ready=0; one multiplier operation per cycle.
  - The multiplier r input = rand_in (or LFSR bits, see Optional Feature) in that cycle.
  - Result is written at the end of the cycle. Step sequence:
    - step 0: x2 = x*x
    - step 1: x3 = x2*x; acc = x3
    - steps 2, 3: acc = acc*acc; at step 3 also x12 = result
    - step 4: acc = acc*x3 (x^15)
    - steps 5-8: acc = acc*acc (x^240)
    - step 9: acc = acc*x12 (x^252)
    - step 10: acc = acc*x2 (x^254), then go to DONE.
- DONE:
  - out_valid=1, out_data=acc.
  - out_data is held stable until out_ready is sampled high. Then out_valid=0 and state returns to IDLE.
  - in_ready stays 0 in DONE; a new input is accepted no earlier than the cycle after the output handshake.
- Latency:
  - Input accepted at edge T; out_valid is high from the cycle beginning at edge T+11.
  - Minimum initiation interval: 13 cycles (out_ready tied high).
- in_valid while not in IDLE is ignored; in_data is not sampled.
- x=0 gives result 0; no special case is needed.
- All arithmetic is carried in 8+d bits. No reduction happens outside the multiplier.
- out_data must never be driven from the combinational multiplier output; it is a register only.

Optional Feature:
- Macro: RAMBAM_INV_LFSR_EN.
- Defined:
  - A 32-bit Galois LFSR (polynomial x^32+x^22+x^2+x+1, reset seed 32'hACE1_2468) advances every COMPUTE cycle. Its low d bits drive r.
  - At each input handshake, rand_in is XORed into the low d LFSR bits (reseed).
- Undefined: r = rand_in directly, and no LFSR logic exists.
- Port list is identical in both builds.

Decomposition:
- Shared package types: INV_STEPS=11, enum inv_state_t {IDLE, COMPUTE, DONE}, and enums for operand-select and destination-select per step.
- The per-step table is a case on the step counter inside the block.
- Sub-modules:
  - the existing multiplier, instantiated once;
  - rambam_inv_lfsr, a new sub-module instantiated only under RAMBAM_INV_LFSR_EN.

Test Plan:
- Macro undefined, rand_in=0, in_data=encode(0x53), out_ready=1 -> out_valid appears 11 cycles after acceptance; decode(out_data)=0xCA.
- rand_in random every cycle; inputs encode(0x01), encode(0x02), encode(0x00) -> decoded outputs 0x01, 0x8D, 0x00. Repeat with different random streams: decoded values unchanged.
- All 256 inputs with random rand_in -> decode(out_data) equals the AES inverse table (with 0 mapping to 0).
- out_ready held low 5 cycles in DONE; in_valid pulsed during COMPUTE and DONE -> out_data stable; in_ready=0; no extra input accepted. Handshake completes on the first cycle out_ready is high.
- rst_n asserted at step 6 -> immediately out_valid=0, in_ready=1, out_data=0. A new input encode(0x53) then completes normally with 0xCA.
- Macro defined, rand_in=0 -> decoded results correct. The multiplier r input changes across COMPUTE cycles and the first r matches the LFSR seed's low d bits.
